// File: rtl/coproc_share_arb.sv
// -----------------------------------------------------------------------------
// coproc_share_arb
//
// Shares one coprocessor between two requesters (m0, m1). A single
// transaction is outstanding at a time and moves through four phases:
//
//   IDLE      : pick a requester (round-robin), ack it, latch its command
//   ISSUE     : offer the latched command to the coprocessor until cp_ack_i
//   WAIT_RESP : wait for the coprocessor result, bounded by TIMEOUT_CYCLES
//   DELIVER   : present the result to the owner until it acks
//
// Command word layout (64 bits): [31:0] src0_data, [63:32] src1_data.
// Response word layout (32 bits): result data.
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent in WAIT_RESP before completion is forced
//                   with an all-zero result and err_o set (must be >= 1)
//
// Ports
//   clk_i                  clock, all state on the rising edge
//   rst_i                  asynchronous reset, active low
//   m0/m1_req_i            requester has a command pending
//   m0/m1_rdata_bi         requester command word
//   m0/m1_ack_o            requester command accepted this cycle
//   m0/m1_resp_req_o       response valid for that requester
//   m0/m1_resp_wdata_bo    response data for that requester
//   m0/m1_resp_ack_i       requester consumed the response
//   cp_req_o, cp_wdata_bo  command valid / command word to the coprocessor
//   cp_ack_i               coprocessor accepted the command
//   cp_resp_req_i          coprocessor response valid
//   cp_resp_rdata_bi       coprocessor result
//   cp_resp_ack_o          response consumed (low only while delivering)
//   owner_o                index of the current or last granted requester
//   busy_o                 a transaction is in flight
//   err_o                  sticky: timeout or unexpected coprocessor response
// -----------------------------------------------------------------------------
module coproc_share_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic [63:0] m0_rdata_bi,
  input  logic [63:0] m1_rdata_bi,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic        m0_resp_req_o,
  output logic        m1_resp_req_o,
  output logic [31:0] m0_resp_wdata_bo,
  output logic [31:0] m1_resp_wdata_bo,
  input  logic        m0_resp_ack_i,
  input  logic        m1_resp_ack_i,
  output logic        cp_req_o,
  output logic [63:0] cp_wdata_bo,
  input  logic        cp_ack_i,
  input  logic        cp_resp_req_i,
  input  logic [31:0] cp_resp_rdata_bi,
  output logic        cp_resp_ack_o,
  output logic        owner_o,
  output logic        busy_o,
  output logic        err_o
);

  // Wait counter is at least 8 bits and wide enough to hold TIMEOUT_CYCLES.
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

  // Value of the counter during the last permitted WAIT_RESP cycle: the
  // counter reads N-1 in the N-th cycle, so leaving here gives exactly
  // TIMEOUT_CYCLES cycles of waiting.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    DELIVER   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      cmd_q, cmd_d;
  logic [31:0]      resp_q, resp_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;   // 1: m1 wins a tie, 0: m0 wins a tie
  logic             err_q, err_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic             grant_valid;
  logic             grant_idx;
  logic             owner_resp_ack;
  logic             m0_ack_raw, m1_ack_raw;

  // ---------------------------------------------------------------------------
  // Round-robin pick. A lone requester always wins; on a tie prio_q decides.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_valid = m0_req_i | m1_req_i;
    grant_idx   = m1_req_i & (~m0_req_i | prio_q);
  end

  assign owner_resp_ack = owner_q ? m1_resp_ack_i : m0_resp_ack_i;

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    cmd_d      = cmd_q;
    resp_d     = resp_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    err_d      = err_q;
    wait_d     = wait_q;
    m0_ack_raw = 1'b0;
    m1_ack_raw = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Nothing is outstanding, so any coprocessor response is stray.
        if (cp_resp_req_i) begin
          err_d = 1'b1;
        end
        if (grant_valid) begin
          m0_ack_raw = ~grant_idx;
          m1_ack_raw = grant_idx;
          cmd_d      = grant_idx ? m1_rdata_bi : m0_rdata_bi;
          owner_d    = grant_idx;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        if (cp_ack_i) begin
          if (cp_resp_req_i) begin
            // Zero-latency coprocessor: result arrives with the accept.
            resp_d  = cp_resp_rdata_bi;
            state_d = DELIVER;
          end else begin
            wait_d  = '0;
            state_d = WAIT_RESP;
          end
        end else if (cp_resp_req_i) begin
          // Result for a command not yet accepted: acked and dropped.
          err_d = 1'b1;
        end
      end

      WAIT_RESP: begin
        if (cp_resp_req_i) begin
          resp_d  = cp_resp_rdata_bi;
          state_d = DELIVER;
        end else if (wait_q == WAIT_LAST) begin
          // Coprocessor never answered: complete with zero data and flag it.
          resp_d  = '0;
          err_d   = 1'b1;
          wait_d  = wait_q + CNT_W'(1);
          state_d = DELIVER;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      DELIVER: begin
        // cp_resp_ack_o is low here, so a response now is not consumed, but
        // it can never belong to this transaction.
        if (cp_resp_req_i) begin
          err_d = 1'b1;
        end
        if (owner_resp_ack) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the command and response registers are reset as well, so the data
  // outputs read zero after reset rather than carrying stale transaction data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      resp_q  <= '0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous state, independent of statement order.
      state_q <= state_d;
      cmd_q   <= cmd_d;
      resp_q  <= resp_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The handshake outputs that are decoded straight from IDLE/non-DELIVER are
  // masked with rst_i: the state register sits in IDLE throughout reset, and
  // without the mask a requester holding its request would see an ack while
  // reset is still asserted. On release the very first edge can take a grant.
  assign m0_ack_o      = rst_i & m0_ack_raw;
  assign m1_ack_o      = rst_i & m1_ack_raw;
  assign cp_resp_ack_o = rst_i & (state_q != DELIVER);

  assign m0_resp_req_o    = (state_q == DELIVER) & ~owner_q;
  assign m1_resp_req_o    = (state_q == DELIVER) &  owner_q;
  assign m0_resp_wdata_bo = owner_q ? '0 : resp_q;
  assign m1_resp_wdata_bo = owner_q ? resp_q : '0;

  assign cp_req_o    = (state_q == ISSUE);
  assign cp_wdata_bo = cmd_q;
  assign owner_o     = owner_q;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_coproc_share_arb.sv
// -----------------------------------------------------------------------------
// tb_coproc_share_arb
//
// Bench for coproc_share_arb with TIMEOUT_CYCLES = 8. A transaction-level
// model (flags for "in flight", "command accepted", "result held", a count of
// waiting cycles and the last granted requester) predicts every output; each
// cycle the outputs are compared against it at the falling clock edge and the
// model is advanced at the rising edge from the same input values the DUT
// sees. Directed scenarios add literal expectations, then a randomized phase
// with occasional resets runs against the model.
// -----------------------------------------------------------------------------
module tb_coproc_share_arb;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m1_req_i;
  logic [63:0] m0_rdata_bi, m1_rdata_bi;
  logic        m0_ack_o, m1_ack_o;
  logic        m0_resp_req_o, m1_resp_req_o;
  logic [31:0] m0_resp_wdata_bo, m1_resp_wdata_bo;
  logic        m0_resp_ack_i, m1_resp_ack_i;
  logic        cp_req_o;
  logic [63:0] cp_wdata_bo;
  logic        cp_ack_i;
  logic        cp_resp_req_i;
  logic [31:0] cp_resp_rdata_bi;
  logic        cp_resp_ack_o;
  logic        owner_o, busy_o, err_o;

  always #5 clk = ~clk;

  coproc_share_arb #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .m0_req_i         (m0_req_i),
    .m1_req_i         (m1_req_i),
    .m0_rdata_bi      (m0_rdata_bi),
    .m1_rdata_bi      (m1_rdata_bi),
    .m0_ack_o         (m0_ack_o),
    .m1_ack_o         (m1_ack_o),
    .m0_resp_req_o    (m0_resp_req_o),
    .m1_resp_req_o    (m1_resp_req_o),
    .m0_resp_wdata_bo (m0_resp_wdata_bo),
    .m1_resp_wdata_bo (m1_resp_wdata_bo),
    .m0_resp_ack_i    (m0_resp_ack_i),
    .m1_resp_ack_i    (m1_resp_ack_i),
    .cp_req_o         (cp_req_o),
    .cp_wdata_bo      (cp_wdata_bo),
    .cp_ack_i         (cp_ack_i),
    .cp_resp_req_i    (cp_resp_req_i),
    .cp_resp_rdata_bi (cp_resp_rdata_bi),
    .cp_resp_ack_o    (cp_resp_ack_o),
    .owner_o          (owner_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 64'(act), 64'(exp));
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  bit          mdl_active;   // a transaction is in flight
  bit          mdl_issued;   // its command has been accepted by the coprocessor
  bit          mdl_deliver;  // its result is held for the owner
  bit          mdl_owner;
  bit          mdl_last;     // last granted requester; 1 so m0 wins first tie
  bit          mdl_err;
  int          mdl_waited;
  logic [63:0] mdl_cmd;
  logic [31:0] mdl_resp;

  function automatic void model_reset();
    mdl_active  = 1'b0;
    mdl_issued  = 1'b0;
    mdl_deliver = 1'b0;
    mdl_owner   = 1'b0;
    mdl_last    = 1'b1;
    mdl_err     = 1'b0;
    mdl_waited  = 0;
    mdl_cmd     = '0;
    mdl_resp    = '0;
  endfunction

  // Requester k is granted when nothing is in flight, it asks, and either it
  // asks alone or it was not the last one served.
  function automatic bit grant_of(input bit k);
    bit rk, ro;
    rk = k ? m1_req_i : m0_req_i;
    ro = k ? m0_req_i : m1_req_i;
    return !mdl_active && rk && (!ro || (k != mdl_last));
  endfunction

  task automatic model_step();
    bit g0, g1;
    if (!rst_i) begin
      model_reset();
      return;
    end
    g0 = grant_of(1'b0);
    g1 = grant_of(1'b1);
    if (!mdl_active) begin
      if (cp_resp_req_i) mdl_err = 1'b1;
      if (g0 || g1) begin
        mdl_owner   = g1;
        mdl_cmd     = g1 ? m1_rdata_bi : m0_rdata_bi;
        mdl_active  = 1'b1;
        mdl_issued  = 1'b0;
        mdl_deliver = 1'b0;
      end
    end else if (!mdl_issued) begin
      if (cp_ack_i) begin
        mdl_issued = 1'b1;
        mdl_waited = 0;
        if (cp_resp_req_i) begin
          mdl_resp    = cp_resp_rdata_bi;
          mdl_deliver = 1'b1;
        end
      end else if (cp_resp_req_i) begin
        mdl_err = 1'b1;
      end
    end else if (!mdl_deliver) begin
      if (cp_resp_req_i) begin
        mdl_resp    = cp_resp_rdata_bi;
        mdl_deliver = 1'b1;
      end else begin
        mdl_waited++;
        if (mdl_waited == int'(TMO)) begin
          mdl_resp    = '0;
          mdl_err     = 1'b1;
          mdl_deliver = 1'b1;
        end
      end
    end else begin
      if (cp_resp_req_i) mdl_err = 1'b1;
      if (mdl_owner ? m1_resp_ack_i : m0_resp_ack_i) begin
        mdl_active  = 1'b0;
        mdl_issued  = 1'b0;
        mdl_deliver = 1'b0;
        mdl_last    = mdl_owner;
      end
    end
  endtask

  task automatic compare_all();
    check_bit("m0_ack", m0_ack_o, rst_i && grant_of(1'b0));
    check_bit("m1_ack", m1_ack_o, rst_i && grant_of(1'b1));
    check_bit("cp_req", cp_req_o, mdl_active && !mdl_issued);
    check("cp_wdata", cp_wdata_bo, mdl_cmd);
    check_bit("cp_resp_ack", cp_resp_ack_o, rst_i && !mdl_deliver);
    check_bit("m0_resp_req", m0_resp_req_o, mdl_deliver && !mdl_owner);
    check_bit("m1_resp_req", m1_resp_req_o, mdl_deliver && mdl_owner);
    if (mdl_deliver && !mdl_owner) check("m0_resp_data", 64'(m0_resp_wdata_bo), 64'(mdl_resp));
    if (mdl_deliver && mdl_owner)  check("m1_resp_data", 64'(m1_resp_wdata_bo), 64'(mdl_resp));
    check_bit("owner", owner_o, mdl_owner);
    check_bit("busy", busy_o, mdl_active);
    check_bit("err", err_o, mdl_err);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then leave 1 time unit before the caller drives new inputs.
  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    m0_req_i         = 1'b0;
    m1_req_i         = 1'b0;
    m0_resp_ack_i    = 1'b0;
    m1_resp_ack_i    = 1'b0;
    cp_ack_i         = 1'b0;
    cp_resp_req_i    = 1'b0;
    cp_resp_rdata_bi = '0;
  endtask

  // Finish whatever is in flight with a prompt coprocessor and requesters.
  task automatic drain();
    m0_req_i      = 1'b0;
    m1_req_i      = 1'b0;
    cp_ack_i      = 1'b1;
    m0_resp_ack_i = 1'b1;
    m1_resp_ack_i = 1'b1;
    for (int c = 0; c < 40 && mdl_active; c++) begin
      cp_resp_req_i    = mdl_issued && !mdl_deliver;
      cp_resp_rdata_bi = $urandom;
      cyc();
    end
    drive_idle();
    #1;
    check_bit("drain_idle", busy_o, 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    model_reset();
    cyc();
    cyc();
    rst_i = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] order  [4];
    logic [1:0] owners [4];
    int         ngr;

    rst_i       = 1'b0;
    m0_rdata_bi = '0;
    m1_rdata_bi = '0;
    drive_idle();
    model_reset();
    #1;
    // Reset state
    check_bit("rst_busy", busy_o, 1'b0);
    check_bit("rst_cp_req", cp_req_o, 1'b0);
    check_bit("rst_err", err_o, 1'b0);
    check_bit("rst_owner", owner_o, 1'b0);
    check_bit("rst_cp_resp_ack", cp_resp_ack_o, 1'b0);
    cyc();
    cyc();
    rst_i = 1'b1;

    // ---- Single request, coprocessor answers one cycle after accepting ----
    m0_req_i    = 1'b1;
    m0_rdata_bi = 64'h0000_0000_1234_5678;
    m1_rdata_bi = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    check_bit("t1_m0_ack", m0_ack_o, 1'b1);
    check_bit("t1_m1_ack", m1_ack_o, 1'b0);
    cyc();
    m0_req_i = 1'b0;
    cp_ack_i = 1'b1;
    #1;
    check_bit("t1_cp_req", cp_req_o, 1'b1);
    check("t1_cp_wdata", cp_wdata_bo, 64'h0000_0000_1234_5678);
    check_bit("t1_m0_ack_once", m0_ack_o, 1'b0);
    cyc();
    cp_ack_i = 1'b0;
    cyc();
    cp_resp_req_i    = 1'b1;
    cp_resp_rdata_bi = 32'hCAFE_BABE;
    cyc();
    cp_resp_req_i    = 1'b0;
    cp_resp_rdata_bi = '0;
    m0_resp_ack_i    = 1'b1;
    #1;
    check_bit("t1_m0_resp_req", m0_resp_req_o, 1'b1);
    check("t1_m0_resp_data", 64'(m0_resp_wdata_bo), 64'h0000_0000_CAFE_BABE);
    check_bit("t1_m1_resp_req", m1_resp_req_o, 1'b0);
    cyc();
    m0_resp_ack_i = 1'b0;
    #1;
    check_bit("t1_done", busy_o, 1'b0);

    // ---- Contention from reset: grants must alternate m0, m1, m0, m1 ----
    do_reset();
    m0_req_i      = 1'b1;
    m1_req_i      = 1'b1;
    m0_resp_ack_i = 1'b1;
    m1_resp_ack_i = 1'b1;
    cp_ack_i      = 1'b1;
    ngr = 0;
    for (int i = 0; i < 4; i++) begin
      order[i]  = 2'b11;
      owners[i] = 2'b11;
    end
    for (int c = 0; c < 60 && ngr < 4; c++) begin
      bit granted;
      cp_resp_req_i    = mdl_issued && !mdl_deliver;
      cp_resp_rdata_bi = $urandom;
      m0_rdata_bi      = {$urandom, $urandom};
      m1_rdata_bi      = {$urandom, $urandom};
      #1;
      granted = 1'b0;
      if (m0_ack_o) begin
        order[ngr] = 2'd0;
        granted    = 1'b1;
      end else if (m1_ack_o) begin
        order[ngr] = 2'd1;
        granted    = 1'b1;
      end
      cyc();
      if (granted) begin
        owners[ngr] = {1'b0, owner_o};
        ngr++;
      end
    end
    check("t2_grant_count", 64'(ngr), 64'd4);
    check("t2_grant0", 64'(order[0]), 64'd0);
    check("t2_grant1", 64'(order[1]), 64'd1);
    check("t2_grant2", 64'(order[2]), 64'd0);
    check("t2_grant3", 64'(order[3]), 64'd1);
    check("t2_owner0", 64'(owners[0]), 64'd0);
    check("t2_owner1", 64'(owners[1]), 64'd1);
    check("t2_owner2", 64'(owners[2]), 64'd0);
    check("t2_owner3", 64'(owners[3]), 64'd1);
    drain();

    // ---- Backpressure: cp_ack_i late by 5 cycles, m0_resp_ack_i by 4 ----
    m0_req_i    = 1'b1;
    m1_req_i    = 1'b1;
    m0_rdata_bi = 64'hA5A5_0001_0BAD_F00D;
    m1_rdata_bi = 64'h1111_2222_3333_4444;
    #1;
    check_bit("t3_m0_ack", m0_ack_o, 1'b1);
    check_bit("t3_m1_ack", m1_ack_o, 1'b0);
    cyc();
    m0_req_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cp_ack_i = (c == 5);
      #1;
      check_bit("t3_cp_req_held", cp_req_o, 1'b1);
      check("t3_cmd_held", cp_wdata_bo, 64'hA5A5_0001_0BAD_F00D);
      check_bit("t3_no_grant_issue", m1_ack_o, 1'b0);
      cyc();
    end
    cp_ack_i         = 1'b0;
    cp_resp_req_i    = 1'b1;
    cp_resp_rdata_bi = 32'h600D_D00D;
    cyc();
    cp_resp_req_i    = 1'b0;
    cp_resp_rdata_bi = '0;
    for (int c = 0; c < 5; c++) begin
      m0_resp_ack_i = (c == 4);
      #1;
      check_bit("t3_resp_held", m0_resp_req_o, 1'b1);
      check("t3_resp_data", 64'(m0_resp_wdata_bo), 64'h0000_0000_600D_D00D);
      check_bit("t3_no_grant_deliver", m1_ack_o, 1'b0);
      cyc();
    end
    m0_resp_ack_i = 1'b0;
    #1;
    check_bit("t3_m1_granted_after", m1_ack_o, 1'b1);
    cyc();
    drain();

    // ---- Timeout: coprocessor accepts but never answers ----
    #1;
    check_bit("t4_err_before", err_o, 1'b0);
    m0_req_i    = 1'b1;
    m0_rdata_bi = 64'h0000_0042_0000_0017;
    #1;
    check_bit("t4_m0_ack", m0_ack_o, 1'b1);
    cyc();
    m0_req_i = 1'b0;
    cp_ack_i = 1'b1;
    cyc();
    cp_ack_i = 1'b0;
    for (int c = 0; c < int'(TMO); c++) begin
      #1;
      check_bit("t4_waiting_no_resp", m0_resp_req_o, 1'b0);
      check_bit("t4_waiting_busy", busy_o, 1'b1);
      cyc();
    end
    m0_resp_ack_i = 1'b1;
    #1;
    check_bit("t4_timeout_resp_req", m0_resp_req_o, 1'b1);
    check("t4_timeout_data", 64'(m0_resp_wdata_bo), 64'd0);
    check_bit("t4_err_set", err_o, 1'b1);
    cyc();
    m0_resp_ack_i    = 1'b0;
    cp_resp_req_i    = 1'b1;
    cp_resp_rdata_bi = 32'h1212_1212;
    #1;
    check_bit("t4_stray_acked", cp_resp_ack_o, 1'b1);
    cyc();
    cp_resp_req_i    = 1'b0;
    cp_resp_rdata_bi = '0;
    #1;
    check_bit("t4_err_sticky", err_o, 1'b1);
    check_bit("t4_stray_dropped", m0_resp_req_o, 1'b0);
    check_bit("t4_stray_idle", busy_o, 1'b0);
    cyc();

    // ---- Reset while waiting for the coprocessor ----
    m1_req_i    = 1'b1;
    m1_rdata_bi = 64'h0BAD_CAFE_0000_0001;
    #1;
    check_bit("t5_m1_ack", m1_ack_o, 1'b1);
    cyc();
    m1_req_i = 1'b0;
    cp_ack_i = 1'b1;
    cyc();
    cp_ack_i = 1'b0;
    cyc();
    #1;
    check_bit("t5_pre_busy", busy_o, 1'b1);
    check_bit("t5_pre_owner", owner_o, 1'b1);
    rst_i    = 1'b0;
    m0_req_i = 1'b1;
    model_reset();
    #1;
    check_bit("t5_rst_busy", busy_o, 1'b0);
    check_bit("t5_rst_err", err_o, 1'b0);
    check_bit("t5_rst_owner", owner_o, 1'b0);
    check_bit("t5_rst_cp_req", cp_req_o, 1'b0);
    check_bit("t5_rst_cp_resp_ack", cp_resp_ack_o, 1'b0);
    check_bit("t5_rst_m0_ack", m0_ack_o, 1'b0);
    check_bit("t5_rst_resp_req", m0_resp_req_o | m1_resp_req_o, 1'b0);
    check("t5_rst_cmd", cp_wdata_bo, 64'd0);
    cyc();
    rst_i    = 1'b1;
    m0_req_i = 1'b0;
    m1_req_i = 1'b1;
    #1;
    check_bit("t5_first_grant_m1", m1_ack_o, 1'b1);
    check_bit("t5_first_grant_m0", m0_ack_o, 1'b0);
    cyc();
    drain();

    // ---- Randomized traffic with occasional resets ----
    for (int c = 0; c < 1500; c++) begin
      rst_i         = ($urandom_range(0, 299) != 0);
      if (!rst_i) model_reset();
      m0_req_i      = 1'($urandom_range(0, 1));
      m1_req_i      = 1'($urandom_range(0, 1));
      m0_rdata_bi   = {$urandom, $urandom};
      m1_rdata_bi   = {$urandom, $urandom};
      cp_ack_i      = 1'($urandom_range(0, 1));
      if (mdl_issued && !mdl_deliver) cp_resp_req_i = ($urandom_range(0, 9) < 3);
      else                            cp_resp_req_i = ($urandom_range(0, 99) < 2);
      cp_resp_rdata_bi = $urandom;
      m0_resp_ack_i = 1'($urandom_range(0, 1));
      m1_resp_ack_i = 1'($urandom_range(0, 1));
      cyc();
    end
    rst_i = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/coproc_share_arb.md
COPROC_SHARE_ARB -- requirements
Module: coproc_share_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles spent in WAIT_RESP before the block forces completion.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state on rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_req_i and m1_req_i, input, 1 bit each: requester k has a command pending.
REQ-005 SHALL have ports m0_rdata_bi and m1_rdata_bi, input, req_struct: requester k command (src0_data, src1_data, ...).
REQ-006 SHALL have ports m0_ack_o and m1_ack_o, output, 1 bit each: requester k command accepted this cycle.
REQ-007 SHALL have ports m0_resp_req_o and m1_resp_req_o, output, 1 bit each: response valid for requester k.
REQ-008 SHALL have ports m0_resp_wdata_bo and m1_resp_wdata_bo, output, resp_struct: response data for requester k.
REQ-009 SHALL have ports m0_resp_ack_i and m1_resp_ack_i, input, 1 bit each: requester k consumed the response.
REQ-010 SHALL have port cp_req_o, output, 1 bit: command valid to the coprocessor.
REQ-011 SHALL have port cp_wdata_bo, output, req_struct: command to the coprocessor.
REQ-012 SHALL have port cp_ack_i, input, 1 bit: coprocessor accepted the command.
REQ-013 SHALL have port cp_resp_req_i, input, 1 bit: coprocessor response valid.
REQ-014 SHALL have port cp_resp_rdata_bi, input, resp_struct: coprocessor result.
REQ-015 SHALL have port cp_resp_ack_o, output, 1 bit: response consumed.
REQ-016 SHALL have port owner_o, output, 1 bit: index of the current or last grant.
REQ-017 SHALL have port busy_o, output, 1 bit: FSM not in IDLE.
REQ-018 SHALL have port err_o, output, 1 bit: sticky error flag.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_RESP and DELIVER, with one transaction outstanding at a time.
REQ-020 SHALL, in IDLE, grant round-robin:
- a single requesting master wins;
- when both request, the master other than the last granted wins;
- the priority pointer resets to favour m0.
REQ-021 SHALL, in the IDLE cycle a grant is made:
- assert mk_ack_o for exactly that cycle;
- register mk_rdata_bi into an internal command register;
- set owner_o;
- move to ISSUE on the next edge.
REQ-022 SHALL, in ISSUE, drive cp_req_o=1 and cp_wdata_bo from the command register, and hold both until cp_ack_i=1, then move to WAIT_RESP.
REQ-023 SHALL hold cp_resp_ack_o=1 in every state except DELIVER.
REQ-024 SHALL, when cp_resp_req_i=1 in WAIT_RESP:
- capture cp_resp_rdata_bi;
- move to DELIVER.
REQ-025 SHALL accept cp_resp_req_i=1 while in ISSUE in the same cycle as cp_ack_i, treat it as per REQ-024, and move directly to DELIVER.
REQ-026 SHALL, in DELIVER:
- drive m<owner>_resp_req_o=1 with the captured data until m<owner>_resp_ack_i=1;
- then return to IDLE and flip the priority pointer.
REQ-027 SHALL keep mk_resp_req_o=0 for the non-owner at all times.
REQ-028 SHALL keep an 8+ bit wait counter that clears on entry to WAIT_RESP and increments each WAIT_RESP cycle.
REQ-029 SHALL, when the wait counter reaches TIMEOUT_CYCLES:
- set err_o;
- capture the response as all-zero;
- move to DELIVER.
REQ-030 SHALL, when cp_resp_req_i=1 outside WAIT_RESP (other than the case in REQ-025):
- acknowledge the response (except in DELIVER);
- drop it;
- set err_o.
REQ-031 SHALL clear err_o only by reset.
REQ-032 SHALL give a one-transaction latency of 3 cycles plus coprocessor latency, from mk_req_i rising in IDLE to mk_resp_req_o, when cp_ack_i is immediate.
REQ-033 SHALL ignore an mk_req_i that is dropped before its grant; no state changes.
REQ-034 SHALL keep all mk_ack_o=0 outside IDLE, while requests stay pending.

Reset
REQ-035 SHALL, while rst_i=0, asynchronously force:
- FSM to IDLE;
- cp_req_o, all ack and resp_req outputs, busy_o, err_o and owner_o to 0;
- data registers to 0;
- the priority pointer to m0.
REQ-036 SHALL, on reset mid-transaction, abandon the transaction and issue no response afterwards.
REQ-037 SHALL leave outputs combinationally independent of rst_i deassertion timing, with the first grant possible on the first edge after release.

Verification
REQ-038 SHALL be verified for single request: m0 requests src0=0x12345678, src1=0; coprocessor returns 0xCAFEBABE after 1 cycle -> m0_ack_o pulses once, cp_wdata_bo carries 0x12345678, m0_resp_wdata_bo=0xCAFEBABE, m1 sees nothing.
REQ-039 SHALL be verified for contention: m0 and m1 request in the same cycle from reset, both held continuously -> grant order m0, m1, m0, m1; owner_o toggles accordingly.
REQ-040 SHALL be verified for backpressure: cp_ack_i held low 5 cycles, then m0_resp_ack_i held low 4 cycles -> cp_req_o and command stable for 6 cycles; response held stable until ack; no new grant.
REQ-041 SHALL be verified for timeout: with TIMEOUT_CYCLES=8, coprocessor never responds -> after 8 WAIT_RESP cycles the owner receives 0x00000000, err_o=1 and stays 1; a later stray cp_resp_req_i is acknowledged and dropped.
REQ-042 SHALL be verified for reset mid-operation: rst_i asserted in WAIT_RESP -> all outputs 0 immediately; after release, m1 alone requests and is granted.
